// File: rtl/cdb_writeback_ctrl.sv
// CDB arbiter and register-file writeback/rename sequencer; ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
// Grant one cycle after req is seen, register pulses one cycle later (one broadcast per 3 cycles); renames stall via issue_ready.
module cdb_writeback_ctrl #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 3,
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*9-1:0]  req_tag,
  input  logic [NUM_REQ*9-1:0]  req_data,
  output logic [NUM_REQ-1:0]    grant,
  input  logic                  issue_valid,
  input  logic [REG_IDX_W-1:0]  issue_reg,
  input  logic [8:0]            issue_tag,
  output logic                  issue_ready,
  input  logic [NUM_REGS*9-1:0] reg_label,
  output logic                  cdb_valid,
  output logic [8:0]            cdb_tag,
  output logic [8:0]            cdb_data,
  output logic [NUM_REGS-1:0]   data_ctrl,
  output logic [NUM_REGS-1:0]   label_ctrl,
  output logic [8:0]            reg_data_in,
  output logic [NUM_REGS*9-1:0] reg_label_in
);

  localparam int REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [8:0] NO_TAG = 9'h1FF;

  typedef enum logic [1:0] {IDLE, REN, BCAST, WB} stateT;

  stateT                 state;
  logic                  lastWasRen;
  logic                  renameDeferred;
  logic                  issueInRange;
  logic [REQ_IDX_W-1:0]  winner;
  logic [NUM_REQ-1:0]    winnerOneHot;
  logic [NUM_REGS-1:0]   tagMatch;

  // A rename right after a rename yields to any pending broadcast so the CDB cannot starve.
  assign renameDeferred = lastWasRen && (|req);
  assign issue_ready    = (state == IDLE) && !renameDeferred;
  assign issueInRange   = ({1'b0, issue_reg} < (REG_IDX_W+1)'(NUM_REGS));
  assign winnerOneHot   = NUM_REQ'(1) << winner;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) winner = REQ_IDX_W'(k);
    end
  end
`else
  logic [REQ_IDX_W-1:0] rrPtr;
  logic [REQ_IDX_W:0]   cand;
  logic                 found;

  always_comb begin
    winner = rrPtr;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rrPtr} + (REQ_IDX_W+1)'(k);
      if (cand >= (REQ_IDX_W+1)'(NUM_REQ)) cand = cand - (REQ_IDX_W+1)'(NUM_REQ);
      if (!found && req[cand[REQ_IDX_W-1:0]]) begin
        winner = cand[REQ_IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end
`endif

  // The reserved tag marks "no pending producer" and must never match.
  always_comb begin
    tagMatch = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      tagMatch[j] = (cdb_tag != NO_TAG) && (reg_label[9*j +: 9] == cdb_tag);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lastWasRen   <= 1'b0;
      grant        <= '0;
      cdb_valid    <= 1'b0;
      cdb_tag      <= '0;
      cdb_data     <= '0;
      data_ctrl    <= '0;
      label_ctrl   <= '0;
      reg_data_in  <= '0;
      reg_label_in <= {NUM_REGS{NO_TAG}};
`ifndef ARB_FIXED_PRIO_EN
      rrPtr        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid && issue_ready) begin
            state      <= REN;
            lastWasRen <= 1'b1;
            if (issueInRange) begin
              label_ctrl[issue_reg]          <= 1'b1;
              reg_label_in[9*issue_reg +: 9] <= issue_tag;
            end
          end else if (|req) begin
            state      <= BCAST;
            lastWasRen <= 1'b0;
            grant      <= winnerOneHot;
            cdb_valid  <= 1'b1;
            cdb_tag    <= req_tag[9*winner +: 9];
            cdb_data   <= req_data[9*winner +: 9];
`ifndef ARB_FIXED_PRIO_EN
            rrPtr      <= (winner == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`endif
          end
        end
        REN: begin
          state        <= IDLE;
          label_ctrl   <= '0;
          reg_label_in <= {NUM_REGS{NO_TAG}};
        end
        BCAST: begin
          state      <= WB;
          grant      <= '0;
          cdb_valid  <= 1'b0;
          data_ctrl  <= tagMatch;
          label_ctrl <= tagMatch;
          if (|tagMatch) reg_data_in <= cdb_data;
        end
        WB: begin
          state        <= IDLE;
          data_ctrl    <= '0;
          label_ctrl   <= '0;
          reg_label_in <= {NUM_REGS{NO_TAG}};
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdb_writeback_ctrl.sv
// Randomized scoreboard bench for cdb_writeback_ctrl: the driver queues expected broadcasts/renames,
// a negedge monitor pops and compares them against a spec-level arbitration and timing model.
module tb_cdb_writeback_ctrl;

  localparam int NUM_REQ  = 3;
  localparam int NUM_REGS = 3;
  localparam logic [8:0]  NO_TAG     = 9'h1FF;
  localparam logic [26:0] ALL_NO_TAG = {3{9'h1FF}};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [26:0] req_tag, req_data;
  logic [2:0]  grant;
  logic        issue_valid;
  logic [1:0]  issue_reg;
  logic [8:0]  issue_tag;
  logic        issue_ready;
  logic [26:0] reg_label;
  logic        cdb_valid;
  logic [8:0]  cdb_tag, cdb_data;
  logic [2:0]  data_ctrl, label_ctrl;
  logic [8:0]  reg_data_in;
  logic [26:0] reg_label_in;

  cdb_writeback_ctrl #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_data(req_data), .grant(grant),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_tag(issue_tag), .issue_ready(issue_ready),
    .reg_label(reg_label), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .data_ctrl(data_ctrl), .label_ctrl(label_ctrl), .reg_data_in(reg_data_in), .reg_label_in(reg_label_in)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [8:0] tag; logic [8:0] data; } bcastT;
  typedef struct packed { logic [1:0] idx; logic [8:0] tag; } renT;

  bcastT expQ[NUM_REQ][$];
  renT   renQ[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin: first requester at or after ptr; fixed priority is the same search with ptr pinned at 0.
  function automatic int expWinner(input logic [2:0] r, input int ptr);
    int w = -1;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (r[(ptr + k) % NUM_REQ]) w = (ptr + k) % NUM_REQ;
    end
    return w;
  endfunction

  function automatic logic [8:0] randTag();
    case ($urandom_range(0, 4))
      0: return 9'h005;
      1: return 9'h011;
      2: return 9'h022;
      3: return NO_TAG;
      default: return 9'($urandom);
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [2:0]  prevReq;
  logic        prevIV, prevIR;
  bit          prevIdle, lastRen, wbNext;
  bit          renNow, bcastNow, wbNow, idleNow;
  logic [8:0]  wbTag, wbData;
  logic [2:0]  wbMask, expG;
  logic [26:0] expRli;
  int          modelPtr, w;
  bcastT       e;
  renT         rn;

  initial begin
    prevIdle = 1; lastRen = 0; wbNext = 0; modelPtr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevIdle = 1; lastRen = 0; wbNext = 0; modelPtr = 0;
        foreach (expQ[i]) expQ[i].delete();
        renQ.delete();
      end else begin
        renNow   = prevIdle && prevIV && prevIR;
        bcastNow = prevIdle && !renNow && (prevReq != 0);
        wbNow    = wbNext;
        idleNow  = !renNow && !bcastNow && !wbNow;
        chk("grant_timing", grant != 0, bcastNow);
        if (bcastNow) begin
          w = expWinner(prevReq, modelPtr);
          expG = '0;
          expG[w] = 1'b1;
          chk("grant", grant, expG);
          chk("cdb_valid_bcast", cdb_valid, 1);
          chk("bcast_no_pulse", {data_ctrl, label_ctrl}, 0);
          chk("bcast_expect_missing", expQ[w].size() == 0, 0);
          if (expQ[w].size() != 0) begin
            e = expQ[w].pop_front();
            chk("cdb_tag", cdb_tag, e.tag);
            chk("cdb_data", cdb_data, e.data);
            wbTag = e.tag; wbData = e.data;
            wbMask = '0;
            for (int j = 0; j < NUM_REGS; j++)
              if (e.tag != NO_TAG && reg_label[9*j +: 9] == e.tag) wbMask[j] = 1'b1;
          end
          wbNext = 1; lastRen = 0;
`ifdef ARB_FIXED_PRIO_EN
          modelPtr = 0;
`else
          modelPtr = (w + 1) % NUM_REQ;
`endif
        end else if (wbNow) begin
          chk("wb_data_ctrl", data_ctrl, wbMask);
          chk("wb_label_ctrl", label_ctrl, wbMask);
          chk("wb_reg_label_in", reg_label_in, ALL_NO_TAG);
          chk("wb_cdb_valid", cdb_valid, 0);
          chk("wb_cdb_tag_hold", cdb_tag, wbTag);
          chk("wb_cdb_data_hold", cdb_data, wbData);
          if (wbMask != 0) chk("wb_reg_data_in", reg_data_in, wbData);
          wbNext = 0;
        end else if (renNow) begin
          chk("ren_expect_missing", renQ.size() == 0, 0);
          if (renQ.size() != 0) begin
            rn = renQ.pop_front();
            expRli = ALL_NO_TAG;
            expG = '0;
            if (rn.idx < 2'(NUM_REGS)) begin
              expRli[9*rn.idx +: 9] = rn.tag;
              expG[rn.idx] = 1'b1;
            end
            chk("ren_label_ctrl", label_ctrl, expG);
            chk("ren_reg_label_in", reg_label_in, expRli);
          end
          chk("ren_data_ctrl", data_ctrl, 0);
          chk("ren_cdb_valid", cdb_valid, 0);
          lastRen = 1;
        end else begin
          chk("idle_pulses", {data_ctrl, label_ctrl}, 0);
          chk("idle_reg_label_in", reg_label_in, ALL_NO_TAG);
          chk("idle_cdb_valid", cdb_valid, 0);
        end
        chk("issue_ready", issue_ready, idleNow && !(lastRen && (req != 0)));
        prevIdle = idleNow;
      end
      prevReq = req; prevIV = issue_valid; prevIR = issue_ready;
    end
  end

  // ---------------- driver ----------------
  task automatic newReq(input int i, input logic [8:0] tag, input logic [8:0] data);
    bcastT b;
    b.tag = tag; b.data = data;
    req[i] = 1'b1;
    req_tag[9*i +: 9] = tag;
    req_data[9*i +: 9] = data;
    expQ[i].push_back(b);
  endtask

  task automatic newRen(input logic [1:0] idx, input logic [8:0] tag);
    renT r;
    r.idx = idx; r.tag = tag;
    issue_valid = 1'b1; issue_reg = idx; issue_tag = tag;
    renQ.push_back(r);
  endtask

  // One cycle: granted requesters drop or re-request, an accepted rename drops or is replaced.
  task automatic step(input bit reReq, input bit reRen);
    logic [2:0] g;
    bit hs;
    @(negedge clk);
    g  = grant;
    hs = issue_valid && issue_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && g[i]) begin
        if (reReq) newReq(i, randTag(), 9'($urandom));
        else req[i] = 1'b0;
      end
    end
    if (hs) begin
      if (reRen) newRen(2'($urandom_range(0, 2)), randTag());
      else issue_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    int total = 0;
    while ((req != 0 || issue_valid) && n < 60) begin
      step(0, 0);
      n++;
    end
    chk("drain_bound", (req != 0) || issue_valid, 0);
    repeat (4) step(0, 0);
    foreach (expQ[i]) total += expQ[i].size();
    total += renQ.size();
    chk("drain_queues", total, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int j;
    rst = 1'b1; req = '0; req_tag = '0; req_data = '0;
    issue_valid = 1'b0; issue_reg = '0; issue_tag = '0;
    reg_label = ALL_NO_TAG;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_ctrl", {data_ctrl, label_ctrl}, 0);
    chk("rst_reg_data_in", reg_data_in, 0);
    chk("rst_reg_label_in", reg_label_in, ALL_NO_TAG);
    chk("rst_issue_ready", issue_ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    // single broadcast into r1
    reg_label = {9'h100, 9'h005, 9'h00A};
    newReq(2, 9'h005, 9'h0A3);
    drain();

    // all units requesting continuously
    for (int i = 0; i < NUM_REQ; i++) newReq(i, randTag(), 9'($urandom));
    repeat (12) step(1, 0);
    drain();

    // lone rename
    newRen(2'd2, 9'h011);
    drain();

    // rename and request both held: renames must not starve the CDB
    newReq(0, 9'h00A, 9'h055);
    newRen(2'd0, 9'h033);
    repeat (12) step(1, 1);
    drain();

    // reserved tag and a tag that matches nothing
    reg_label = {NO_TAG, 9'h022, NO_TAG};
    newReq(1, NO_TAG, 9'h0F0);
    drain();
    newReq(0, 9'h0EE, 9'h00F);
    drain();

    // rename to a register index beyond the file
    newRen(2'd3, 9'h044);
    drain();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        if (!req[i] && $urandom_range(0, 9) < 3) newReq(i, randTag(), 9'($urandom));
      if (!issue_valid && $urandom_range(0, 3) == 0) newRen(2'($urandom_range(0, 3)), randTag());
      if ($urandom_range(0, 4) == 0) begin
        j = $urandom_range(0, 2);
        reg_label[9*j +: 9] = randTag();
      end
    end
    drain();

    // all registers share a tag, then reset lands in the WB cycle
    reg_label = {3{9'h055}};
    newReq(1, 9'h055, 9'h1C3);
    n = 0;
    while (data_ctrl == 0 && n < 10) begin
      step(0, 0);
      n++;
    end
    chk("wb_multi_match", data_ctrl, 3'b111);
    chk("wb_multi_data", reg_data_in, 9'h1C3);
    #1;
    rst = 1'b1; req = '0; issue_valid = 1'b0;
    #1;
    chk("midrst_data_ctrl", data_ctrl, 0);
    chk("midrst_label_ctrl", label_ctrl, 0);
    chk("midrst_reg_label_in", reg_label_in, ALL_NO_TAG);
    chk("midrst_grant", {grant, cdb_valid}, 0);
    chk("midrst_issue_ready", issue_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // pointer back at requester 0 after reset
    reg_label = {9'h011, 9'h022, 9'h005};
    for (int i = 0; i < NUM_REQ; i++) newReq(i, randTag(), 9'($urandom));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_writeback_ctrl.md
# cdb_writeback_ctrl

Sequencer for the Tomasulo-style register file (9-bit data plus 9-bit label per register). It round-robin arbitrates functional-unit result requests onto a single common data bus (CDB) and drives the registers' edge-triggered data and label controls to write back broadcast results. It also applies renames from the issue stage. It sits between the functional units and the register file, and it is the only driver of the registers' control inputs.

## Interface
- NUM_REQ, 3, number of CDB requesters (functional units)
- NUM_REGS, 3, number of architectural registers controlled
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  result request per unit; held until granted
- req_tag  in  NUM_REQ*9  producer tag per unit (unit i at [9i+8:9i])
- req_data  in  NUM_REQ*9  result data per unit
- grant  out  NUM_REQ  one-hot, one-cycle grant
- issue_valid  in  1  rename request
- issue_reg  in  $clog2(NUM_REGS)  destination register index
- issue_tag  in  9  new producer tag for issue_reg
- issue_ready  out  1  rename accepted at the edge where issue_valid && issue_ready
- reg_label  in  NUM_REGS*9  current label of each register
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  9  broadcast tag
- cdb_data  out  9  broadcast data
- data_ctrl  out  NUM_REGS  per-register data write pulse
- label_ctrl  out  NUM_REGS  per-register label write pulse
- reg_data_in  out  9  data presented to all registers
- reg_label_in  out  NUM_REGS*9  label presented to each register

## Operation
- Tag 9'h1FF is reserved and means "no pending producer".
- FSM states: IDLE, REN, BCAST, WB. All outputs except issue_ready are registered.
- IDLE:
  - If issue_valid and rename has priority: go to REN.
  - Else if any req: go to BCAST.
  - Else: stay in IDLE.
  - Rename has priority unless the previous non-IDLE state was REN and a req is pending. In that case BCAST wins, and the rename waits with issue_ready low.
- REN (1 cycle):
  - label_ctrl[issue_reg]=1 and reg_label_in[issue_reg]=issue_tag, with both values captured at the accepting edge.
  - If issue_reg >= NUM_REGS, the handshake still completes but no pulse is generated.
  - Next state is IDLE.
- BCAST (1 cycle):
  - grant[w]=1, cdb_valid=1, cdb_tag/cdb_data = req_tag[w]/req_data[w], where w is the winner chosen at the entering edge.
  - Next state is WB.
- WB (1 cycle):
  - For each j with reg_label[j]==cdb_tag (sampled at the entering edge): data_ctrl[j]=1, label_ctrl[j]=1, reg_data_in=cdb_data, reg_label_in[j]=9'h1FF.
  - If cdb_tag==9'h1FF, no register matches.
  - cdb outputs hold their values, cdb_valid=0, grant=0.
  - Next state is IDLE.
- Control pulses only occur in REN and WB, and these states are always separated by IDLE. This guarantees a fresh rising edge on every register write.
- Arbitration: round-robin.
  - The priority pointer starts at the index after the last winner.
  - The pointer resets to 0, so requester 0 has first priority.
- Requester rule: hold req, tag and data stable until the grant is seen, then drop req at the next edge. A requester that keeps req high is treated as a new request.
- issue_ready = (state==IDLE) && !(rename deferred by the fairness rule). This output is combinational.
- Outside pulse cycles, reg_label_in rests at 9'h1FF and reg_data_in holds its last value.

## Timing
- Reset values:
  - state IDLE, RR pointer 0, fairness flag 0
  - grant, cdb_valid, cdb_tag, cdb_data, data_ctrl, label_ctrl, reg_data_in: 0
  - reg_label_in: all 9'h1FF
  - issue_ready: 1
- Broadcast latency:
  - req seen in IDLE at edge E0: grant and cdb_valid are high in cycle E0..E1.
  - Register controls are high in cycle E1..E2.
  - Back in IDLE at E2.
  - Maximum throughput is one broadcast per 3 cycles.
- Rename latency: accepted at E0, label_ctrl high in E0..E1, IDLE at E1.
- Simultaneous rename and request in IDLE: rename first, broadcast in the following IDLE visit. Consecutive renames cannot starve the CDB.
- Multiple registers carrying the same tag are all written in the same WB cycle.
- Reset asserted mid-operation: all pulses drop immediately and the FSM returns to IDLE. No partial write occurs beyond edges already delivered.

## Configuration
- ARB_FIXED_PRIO_EN
  - Defined: fixed priority, where the lowest index wins. The RR pointer is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then r1 label=9'h005, unit 2 requests tag 9'h005, data 9'h0A3:
  - grant=3'b100 for 1 cycle, then data_ctrl=3'b010 and label_ctrl=3'b010, reg_data_in=9'h0A3, reg_label_in[1]=9'h1FF.
- Units 0, 1 and 2 request continuously: grants go 001, 010, 100, 001, each 3 cycles apart. With ARB_FIXED_PRIO_EN, unit 0 is granted repeatedly.
- issue_valid with reg 2, tag 9'h011 in IDLE: label_ctrl=3'b100 for 1 cycle with reg_label_in[2]=9'h011, no data_ctrl.
- Rename and req both held: sequence is REN, IDLE, BCAST, WB, IDLE, REN. issue_ready is low during the deferred IDLE.
- Broadcast of tag 9'h1FF, and a tag matching no register: grant pulses, data_ctrl and label_ctrl stay 0.
- rst asserted during WB: data_ctrl and label_ctrl go to 0 immediately, and reg_label_in returns to 9'h1FF.
